// File: rtl/rvv_backend_retire.sv
// rvv_backend_retire: retire stage taking up to NUM_RT_UOP in-order uops per cycle from the ROB.
// Ports: rd_*_rob2rt  - retire group from the ROB; rd_ready_rt2rob accepts each lane
//        wr_*_rt2vrf  - registered VRF writes with WAW-merged byte strobes (one-cycle pulse)
//        wr_*_rt2xrf  - registered XRF writes, held per lane until wr_ready_xrf2rt
//        vxsat_set_rt2vcsr / trap_done_rt2rvs - registered event pulses; retire_cnt - retired uop total
module rvv_backend_retire #(
  parameter int NUM_RT_UOP = 4,
  parameter int VLEN       = 128,
  parameter int VLENB      = VLEN / 8,
  parameter int XLEN       = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_RT_UOP-1:0]        rd_valid_rob2rt,
  input  logic [NUM_RT_UOP-1:0]        rd_w_valid_rob2rt,
  input  logic [NUM_RT_UOP-1:0]        rd_w_type_rob2rt,
  input  logic [NUM_RT_UOP*5-1:0]      rd_w_index_rob2rt,
  input  logic [NUM_RT_UOP*VLEN-1:0]   rd_w_data_rob2rt,
  input  logic [NUM_RT_UOP*VLENB-1:0]  rd_byte_en_rob2rt,
  input  logic [NUM_RT_UOP-1:0]        rd_vsaturate_rob2rt,
  input  logic [NUM_RT_UOP-1:0]        rd_trap_flag_rob2rt,
  output logic [NUM_RT_UOP-1:0]        rd_ready_rt2rob,
  output logic [NUM_RT_UOP-1:0]        wr_valid_rt2vrf,
  output logic [NUM_RT_UOP*5-1:0]      wr_index_rt2vrf,
  output logic [NUM_RT_UOP*VLEN-1:0]   wr_data_rt2vrf,
  output logic [NUM_RT_UOP*VLENB-1:0]  wr_strobe_rt2vrf,
  output logic [NUM_RT_UOP-1:0]        wr_valid_rt2xrf,
  output logic [NUM_RT_UOP*5-1:0]      wr_index_rt2xrf,
  output logic [NUM_RT_UOP*XLEN-1:0]   wr_data_rt2xrf,
  input  logic [NUM_RT_UOP-1:0]        wr_ready_xrf2rt,
  output logic                         vxsat_set_rt2vcsr,
  output logic                         trap_done_rt2rvs,
  output logic [31:0]                  retire_cnt
);
  localparam int N = NUM_RT_UOP;
  typedef enum logic {RUN, HOLD} state_t;
  state_t state;
  logic stage_free, older_trap;
  logic [N-1:0] commit, vrf_valid_n, xrf_load, pending_n;
  logic [N-1:0][VLENB-1:0] strobe_n;
  logic [VLENB-1:0] mask;
  logic [31:0] acc_cnt;
  always_comb begin
    // wr_valid_rt2xrf doubles as the pending_x bits; the stage frees when every held lane drains now
    stage_free = (state == RUN) | ~|(wr_valid_rt2xrf & ~wr_ready_xrf2rt);
    older_trap = 1'b0;
    acc_cnt = '0;
    rd_ready_rt2rob = '0;
    for (int i = 0; i < N; i++) begin
      rd_ready_rt2rob[i] = stage_free & rd_valid_rob2rt[i] & ~older_trap;
      older_trap = older_trap | (rd_valid_rob2rt[i] & rd_trap_flag_rob2rt[i]);
      acc_cnt = acc_cnt + 32'(rd_ready_rt2rob[i]);
    end
    commit = rd_ready_rt2rob & rd_w_valid_rob2rt & ~rd_trap_flag_rob2rt;
    xrf_load = commit & rd_w_type_rob2rt;
    pending_n = xrf_load | (wr_valid_rt2xrf & ~wr_ready_xrf2rt);
    mask = '0;
    for (int i = 0; i < N; i++) begin
      // younger committing VRF writers to the same register own the bytes they enable
      mask = '0;
      for (int k = i + 1; k < N; k++)
        mask = mask | ((commit[k] & ~rd_w_type_rob2rt[k] &
                        (rd_w_index_rob2rt[k*5 +: 5] == rd_w_index_rob2rt[i*5 +: 5]))
                       ? rd_byte_en_rob2rt[k*VLENB +: VLENB] : '0);
      strobe_n[i] = rd_byte_en_rob2rt[i*VLENB +: VLENB] & ~mask;
      vrf_valid_n[i] = commit[i] & ~rd_w_type_rob2rt[i] & |strobe_n[i];
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
      wr_valid_rt2vrf <= '0;
      wr_index_rt2vrf <= '0;
      wr_data_rt2vrf <= '0;
      wr_strobe_rt2vrf <= '0;
      wr_valid_rt2xrf <= '0;
      wr_index_rt2xrf <= '0;
      wr_data_rt2xrf <= '0;
      vxsat_set_rt2vcsr <= 1'b0;
      trap_done_rt2rvs <= 1'b0;
      retire_cnt <= '0;
    end else begin
      state <= |pending_n ? HOLD : RUN;
      wr_valid_rt2vrf <= vrf_valid_n;
      wr_valid_rt2xrf <= pending_n;
      vxsat_set_rt2vcsr <= |(commit & rd_vsaturate_rob2rt);
      trap_done_rt2rvs <= |(rd_ready_rt2rob & rd_trap_flag_rob2rt);
      retire_cnt <= retire_cnt + acc_cnt;
      for (int i = 0; i < N; i++) begin
        if (commit[i] & ~rd_w_type_rob2rt[i]) begin
          wr_index_rt2vrf[i*5 +: 5] <= rd_w_index_rob2rt[i*5 +: 5];
          wr_data_rt2vrf[i*VLEN +: VLEN] <= rd_w_data_rob2rt[i*VLEN +: VLEN];
          wr_strobe_rt2vrf[i*VLENB +: VLENB] <= strobe_n[i];
        end
        if (xrf_load[i]) begin
          wr_index_rt2xrf[i*5 +: 5] <= rd_w_index_rob2rt[i*5 +: 5];
          wr_data_rt2xrf[i*XLEN +: XLEN] <= rd_w_data_rob2rt[i*VLEN +: XLEN];
        end
      end
    end
  end
endmodule

// File: tb/tb_rvv_backend_retire.sv
// tb_rvv_backend_retire: directed and randomized checks of rvv_backend_retire against a byte-ownership model.
module tb_rvv_backend_retire;
  logic clk = 1'b0, rst = 1'b1;
  logic [3:0] v, wv, wt, sat, trap, xr;
  logic [3:0][4:0] idx;
  logic [3:0][127:0] data;
  logic [3:0][15:0] be;
  logic [3:0] ready, vv, xv;
  logic [3:0][4:0] vi, xi;
  logic [3:0][127:0] vd;
  logic [3:0][15:0] vs;
  logic [3:0][31:0] xd;
  logic vxsat, tdone;
  logic [31:0] cnt;
  logic [3:0] m_vv, m_xv, exp_ready, obs_ready;
  logic [3:0][4:0] m_vi, m_xi;
  logic [3:0][127:0] m_vd;
  logic [3:0][15:0] m_vs;
  logic [3:0][31:0] m_xd;
  logic m_sat, m_trap;
  logic [31:0] m_cnt;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  rvv_backend_retire dut (
    .clk(clk), .rst(rst),
    .rd_valid_rob2rt(v), .rd_w_valid_rob2rt(wv), .rd_w_type_rob2rt(wt),
    .rd_w_index_rob2rt(idx), .rd_w_data_rob2rt(data), .rd_byte_en_rob2rt(be),
    .rd_vsaturate_rob2rt(sat), .rd_trap_flag_rob2rt(trap), .rd_ready_rt2rob(ready),
    .wr_valid_rt2vrf(vv), .wr_index_rt2vrf(vi), .wr_data_rt2vrf(vd), .wr_strobe_rt2vrf(vs),
    .wr_valid_rt2xrf(xv), .wr_index_rt2xrf(xi), .wr_data_rt2xrf(xd), .wr_ready_xrf2rt(xr),
    .vxsat_set_rt2vcsr(vxsat), .trap_done_rt2rvs(tdone), .retire_cnt(cnt)
  );

  task automatic clear_inputs();
    v = '0; wv = '0; wt = '0; sat = '0; trap = '0; xr = '0;
    idx = '0; data = '0; be = '0;
  endtask

  task automatic model_reset();
    m_vv = '0; m_xv = '0; m_vi = '0; m_xi = '0; m_vd = '0; m_vs = '0; m_xd = '0;
    m_sat = 1'b0; m_trap = 1'b0; m_cnt = '0;
  endtask

  // One clock: predict acceptance and the next-cycle outputs by replaying the group's
  // writes in program order into a per-register byte-owner map, then advance the clock.
  task automatic tick();
    int own [32][16];
    int first_trap;
    logic free;
    logic [3:0] com, n_vv;
    logic [3:0][15:0] n_vs;
    #1;
    obs_ready = ready;
    free = ((m_xv & ~xr) == 4'b0);
    first_trap = 4;
    for (int i = 0; i < 4; i++) if (first_trap == 4 && v[i] && trap[i]) first_trap = i;
    exp_ready = '0;
    for (int i = 0; i < 4; i++) if (free && v[i] && i <= first_trap) exp_ready[i] = 1'b1;
    com = exp_ready & wv & ~trap;
    for (int r = 0; r < 32; r++) for (int b = 0; b < 16; b++) own[r][b] = -1;
    for (int i = 0; i < 4; i++)
      if (com[i] && !wt[i]) for (int b = 0; b < 16; b++) if (be[i][b]) own[idx[i]][b] = i;
    n_vs = '0;
    for (int i = 0; i < 4; i++)
      for (int b = 0; b < 16; b++) n_vs[i][b] = com[i] && !wt[i] && own[idx[i]][b] == i;
    for (int i = 0; i < 4; i++) n_vv[i] = n_vs[i] != 16'h0;
    @(posedge clk);
    #1;
    m_vv = n_vv;
    for (int i = 0; i < 4; i++) begin
      if (n_vv[i]) begin m_vi[i] = idx[i]; m_vd[i] = data[i]; m_vs[i] = n_vs[i]; end
      if (com[i] && wt[i]) begin m_xv[i] = 1'b1; m_xi[i] = idx[i]; m_xd[i] = data[i][31:0]; end
      else if (xr[i]) m_xv[i] = 1'b0;
    end
    m_sat = |(com & sat);
    m_trap = |(exp_ready & trap);
    m_cnt = m_cnt + 32'($countones(exp_ready));
  endtask

  task automatic test_reset();
    clear_inputs();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({ready, vv, xv, vxsat, tdone} !== 14'b0 || cnt !== 32'd0) begin
      errors++; $display("FAIL reset_outputs: got ready=%b vrf=%b xrf=%b cnt=%0d exp all 0", ready, vv, xv, cnt);
    end
    checks++;
    if (vs !== '0 || vd !== '0 || xd !== '0) begin errors++; $display("FAIL reset_data: got nonzero, exp 0"); end
    @(negedge clk);
    rst = 1'b0;
    tick();
    checks++;
    if (obs_ready !== 4'b0 || vv !== 4'b0 || cnt !== 32'd0) begin
      errors++; $display("FAIL idle: got ready=%b vrf=%b cnt=%0d exp 0", obs_ready, vv, cnt);
    end
  endtask

  task automatic test_vrf_basic();
    clear_inputs();
    v = 4'hF; wv = 4'hF;
    for (int i = 0; i < 4; i++) begin
      idx[i] = 5'(i + 1); be[i] = 16'hFFFF; data[i] = {$urandom, $urandom, $urandom, $urandom};
    end
    tick();
    checks++;
    if (obs_ready !== 4'hF) begin errors++; $display("FAIL basic_ready: got %b exp 1111", obs_ready); end
    checks++;
    if (vv !== 4'hF || vs !== {4{16'hFFFF}}) begin errors++; $display("FAIL basic_vrf: got valid=%b strobe=%h exp 1111 all FFFF", vv, vs); end
    checks++;
    if (vi !== {5'd4, 5'd3, 5'd2, 5'd1} || vd !== data) begin errors++; $display("FAIL basic_idx_data: got idx=%h exp 4/3/2/1", vi); end
    checks++;
    if (cnt !== 32'd4) begin errors++; $display("FAIL basic_cnt: got %0d exp 4", cnt); end
    clear_inputs();
    tick();
    checks++;
    if (vv !== 4'b0) begin errors++; $display("FAIL vrf_pulse: got %b exp 0000", vv); end
  endtask

  task automatic test_waw();
    clear_inputs();
    v = 4'hF; wv = 4'hF;
    idx[0] = 5'd5; idx[1] = 5'd6; idx[2] = 5'd5; idx[3] = 5'd7;
    be[0] = 16'hFFFF; be[1] = 16'hFFFF; be[2] = 16'h00FF; be[3] = 16'hFFFF;
    tick();
    checks++;
    if (vv !== 4'hF || vs[0] !== 16'hFF00 || vs[2] !== 16'h00FF) begin
      errors++; $display("FAIL waw_partial: got valid=%b s0=%h s2=%h exp 1111 FF00 00FF", vv, vs[0], vs[2]);
    end
    be[2] = 16'hFFFF;
    tick();
    checks++;
    if (vv !== 4'b1110 || vs[2] !== 16'hFFFF) begin
      errors++; $display("FAIL waw_full: got valid=%b s2=%h exp 1110 FFFF", vv, vs[2]);
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_trap();
    logic [31:0] c0;
    c0 = m_cnt;
    clear_inputs();
    v = 4'hF; wv = 4'hF; trap = 4'b0010;
    for (int i = 0; i < 4; i++) begin idx[i] = 5'(8 + i); be[i] = 16'hFFFF; end
    tick();
    checks++;
    if (obs_ready !== 4'b0011) begin errors++; $display("FAIL trap_ready: got %b exp 0011", obs_ready); end
    checks++;
    if (vv !== 4'b0001 || tdone !== 1'b1) begin errors++; $display("FAIL trap_commit: got vrf=%b tdone=%b exp 0001 1", vv, tdone); end
    checks++;
    if (cnt !== c0 + 32'd2) begin errors++; $display("FAIL trap_cnt: got %0d exp %0d", cnt, c0 + 32'd2); end
    clear_inputs();
    tick();
    checks++;
    if (tdone !== 1'b0) begin errors++; $display("FAIL trap_pulse: got %b exp 0", tdone); end
  endtask

  task automatic test_xrf_bp();
    logic [31:0] d;
    clear_inputs();
    v = 4'b0001; wv = 4'b0001; wt = 4'b0001; idx[0] = 5'd7; data[0] = {$urandom, $urandom, $urandom, $urandom};
    d = data[0][31:0];
    tick();
    checks++;
    if (xv !== 4'b0001 || xi[0] !== 5'd7 || xd[0] !== d) begin
      errors++; $display("FAIL xrf_load: got valid=%b idx=%0d data=%h exp 0001 7 %h", xv, xi[0], xd[0], d);
    end
    wt = 4'b0; idx[0] = 5'd12; be[0] = 16'hFFFF; data[0] = ~data[0];
    for (int c = 0; c < 2; c++) begin
      tick();
      checks++;
      if (obs_ready !== 4'b0 || xv !== 4'b0001 || xi[0] !== 5'd7 || xd[0] !== d) begin
        errors++; $display("FAIL xrf_hold: got ready=%b valid=%b idx=%0d data=%h exp 0000 0001 7 %h", obs_ready, xv, xi[0], xd[0], d);
      end
    end
    xr = 4'b0001;
    tick();
    checks++;
    if (obs_ready !== 4'b0001 || xv !== 4'b0 || vv !== 4'b0001) begin
      errors++; $display("FAIL xrf_release: got ready=%b xrf=%b vrf=%b exp 0001 0000 0001", obs_ready, xv, vv);
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_sat_rst();
    clear_inputs();
    v = 4'hF; wv = 4'hF; sat = 4'b1000;
    for (int i = 0; i < 4; i++) begin idx[i] = 5'(13 + i); be[i] = 16'hFFFF; end
    tick();
    checks++;
    if (vxsat !== 1'b1) begin errors++; $display("FAIL sat_pulse: got %b exp 1", vxsat); end
    clear_inputs();
    tick();
    checks++;
    if (vxsat !== 1'b0) begin errors++; $display("FAIL sat_clear: got %b exp 0", vxsat); end
    v = 4'b0111; wv = 4'b0100; wt = 4'b0100; idx[2] = 5'd9;
    tick();
    checks++;
    if (xv !== 4'b0100) begin errors++; $display("FAIL hold_before_rst: got %b exp 0100", xv); end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({vv, xv, vxsat, tdone} !== 10'b0 || cnt !== 32'd0 || xd !== '0) begin
      errors++; $display("FAIL async_rst: got vrf=%b xrf=%b cnt=%0d exp all 0", vv, xv, cnt);
    end
    model_reset();
    clear_inputs();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_random();
    int n;
    for (int c = 0; c < 400; c++) begin
      n = $urandom_range(0, 4);
      v = 4'((1 << n) - 1);
      for (int i = 0; i < 4; i++) begin
        trap[i] = $urandom_range(0, 11) == 0;
        wv[i] = $urandom_range(0, 4) != 0;
        wt[i] = $urandom_range(0, 2) == 0;
        sat[i] = $urandom_range(0, 4) == 0;
        xr[i] = 1'($urandom_range(0, 1));
        idx[i] = 5'($urandom_range(0, 3));
        be[i] = $urandom_range(0, 3) == 0 ? 16'hFFFF : 16'($urandom);
        data[i] = {$urandom, $urandom, $urandom, $urandom};
      end
      tick();
      checks++;
      if (obs_ready !== exp_ready) begin errors++; $display("FAIL rnd_ready: got %b exp %b", obs_ready, exp_ready); end
      checks++;
      if (vv !== m_vv || xv !== m_xv) begin errors++; $display("FAIL rnd_valid: got vrf=%b xrf=%b exp %b %b", vv, xv, m_vv, m_xv); end
      for (int i = 0; i < 4; i++) begin
        if (m_vv[i]) begin
          checks++;
          if (vi[i] !== m_vi[i] || vs[i] !== m_vs[i] || vd[i] !== m_vd[i]) begin
            errors++; $display("FAIL rnd_vrf%0d: got idx=%0d strobe=%h exp %0d %h", i, vi[i], vs[i], m_vi[i], m_vs[i]);
          end
        end
        if (m_xv[i]) begin
          checks++;
          if (xi[i] !== m_xi[i] || xd[i] !== m_xd[i]) begin
            errors++; $display("FAIL rnd_xrf%0d: got idx=%0d data=%h exp %0d %h", i, xi[i], xd[i], m_xi[i], m_xd[i]);
          end
        end
      end
      checks++;
      if (vxsat !== m_sat || tdone !== m_trap || cnt !== m_cnt) begin
        errors++; $display("FAIL rnd_events: got sat=%b trap=%b cnt=%0d exp %b %b %0d", vxsat, tdone, cnt, m_sat, m_trap, m_cnt);
      end
    end
  endtask

  initial begin
    test_reset();
    test_vrf_basic();
    test_waw();
    test_trap();
    test_xrf_bp();
    test_sat_rst();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/rvv_backend_retire.md
Name: rvv_backend_retire

Overview:
- Consumer end of the ROB-to-retire interface.
- Accepts up to NUM_RT_UOP in-order retire uops per cycle from the ROB and resolves write-after-write conflicts inside each group by byte-strobe masking.
- Registers the resulting VRF and XRF writes one cycle later, holds XRF writes until the scalar core accepts them, and suppresses commit after a trapping uop.
- Also reports the vxsat set event, the trap commit and a retired-uop count.

Parameters:
- NUM_RT_UOP, 4, retire lanes per cycle
- VLEN, 128, vector register width in bits
- VLENB, 16, VLEN/8, byte strobes per register
- XLEN, 32, scalar write width (XRF data = w_data[XLEN-1:0])

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous reset, active-high
- rd_valid_rob2rt  input  NUM_RT_UOP  lane valid; lanes form a prefix from lane 0
- rd_w_valid_rob2rt  input  NUM_RT_UOP  uop writes a destination
- rd_w_type_rob2rt  input  NUM_RT_UOP  0 = VRF, 1 = XRF
- rd_w_index_rob2rt  input  NUM_RT_UOP*5  destination register index
- rd_w_data_rob2rt  input  NUM_RT_UOP*VLEN  result data
- rd_byte_en_rob2rt  input  NUM_RT_UOP*VLENB  active-body byte strobes
- rd_vsaturate_rob2rt  input  NUM_RT_UOP  uop saturated
- rd_trap_flag_rob2rt  input  NUM_RT_UOP  uop raised a trap
- rd_ready_rt2rob  output  NUM_RT_UOP  lane accepted
- wr_valid_rt2vrf  output  NUM_RT_UOP  VRF write valid; the VRF always accepts
- wr_index_rt2vrf  output  NUM_RT_UOP*5  VRF index
- wr_data_rt2vrf  output  NUM_RT_UOP*VLEN  VRF data
- wr_strobe_rt2vrf  output  NUM_RT_UOP*VLENB  VRF byte strobes
- wr_valid_rt2xrf  output  NUM_RT_UOP  XRF write valid
- wr_index_rt2xrf  output  NUM_RT_UOP*5  XRF index
- wr_data_rt2xrf  output  NUM_RT_UOP*XLEN  XRF data
- wr_ready_xrf2rt  input  NUM_RT_UOP  XRF accept
- vxsat_set_rt2vcsr  output  1  one-cycle pulse: set vxsat
- trap_done_rt2rvs  output  1  one-cycle pulse: trapping uop committed
- retire_cnt  output  32  total retired uops, wraps modulo 2^32

Behaviour:
- Reset (rst=1, asynchronous): every output register is 0, the output stage is empty, the state is RUN and retire_cnt is 0. Asserting rst mid-hold discards pending XRF writes.
- The output stage is a single register per lane. Per-lane pending_x bits track XRF writes that are presented but not yet accepted.
- stage_free = (no pending_x bit set) OR (every set pending_x bit handshakes this cycle).
- Ready rule: rd_ready_rt2rob[i] = stage_free & rd_valid_rob2rt[i] & (no lane j<i has valid & trap_flag).
  - The trapping lane itself is accepted; lanes younger than it are refused.
- Commit mask: lane i commits iff accepted, w_valid=1 and trap_flag=0. A trapping lane writes nothing.
- VRF WAW merge (combinational, before the register):
  - strobe_out[i] = byte_en[i] & ~OR over committing VRF lanes k>i with equal index of byte_en[k].
  - VRF valid_out[i] = commit & (type=0) & (strobe_out[i] != 0).
- Latency: 1 cycle from the rd handshake to wr_valid_rt2vrf / wr_valid_rt2xrf.
  - wr_valid_rt2vrf is high for exactly 1 cycle. It is cleared on the next clock edge unless a new group is loaded.
  - wr_valid_rt2xrf holds, with stable index and data, until wr_ready_xrf2rt. XRF lanes handshake independently.
  - There is no XRF WAW merge: all committing XRF lanes are presented and are accepted in any order.
- States:
  - RUN: the stage is free, or drains this cycle.
  - HOLD: a pending_x bit survives the cycle. rd_ready_rt2rob = 0 in HOLD.
  - Transitions: HOLD->RUN in the cycle the last pending_x handshakes; ready is asserted in that same cycle, so there is no bubble.
- vxsat_set_rt2vcsr: registered pulse, 1 cycle after a group in which any committing lane has vsaturate=1.
- trap_done_rt2rvs: registered pulse, 1 cycle after a lane with trap_flag=1 is accepted. The ROB flushes in the same handshake cycle, so nothing younger arrives.
- retire_cnt: increments by popcount(accepted lanes), trapping lane included.
- Simultaneous events: XRF drain and a new group load in the same cycle are legal. A lane handshaking its XRF write while being reloaded takes the new value.

Test Plan:
- Reset then idle: outputs all 0; rd_ready=0 while rd_valid=0; retire_cnt=0.
- 4 VRF lanes with indices 1,2,3,4, byte_en=16'hFFFF -> next cycle wr_valid_rt2vrf=4'b1111, strobes all FFFF, retire_cnt=4.
- WAW merge: lane0 v5 byte_en FFFF, lane2 v5 byte_en 00FF -> lane0 strobe FF00, lane2 strobe 00FF; with byte_en of lane2 FFFF, lane0 valid=0.
- Trap: valid=1111, trap_flag on lane1 -> rd_ready=0011; lane1 writes suppressed; trap_done pulse next cycle; retire_cnt += 2.
- XRF backpressure: lane0 XRF x7 with wr_ready_xrf2rt low for 3 cycles -> wr_valid_rt2xrf[0] held 3 cycles, rd_ready=0 during HOLD, ready=1 in the cycle xrf_ready rises.
- Saturation plus async reset: lane3 vsaturate=1 -> vxsat pulse for 1 cycle; rst asserted during HOLD -> all outputs 0 immediately.
